// File: rtl/rtc_captura_datos_if.sv
// rtc_captura_datos_if: burst input and committed snapshot outputs of the RTC capture bank.
interface rtc_captura_datos_if #(
   parameter int N = 8
);
   logic start;
   logic dato_valid;
   logic [N-1:0] dato_in;
   logic [N-1:0] dato_hora, dato_min, dato_seg;
   logic [N-1:0] dato_dia, dato_mes, dato_year;
   logic actualizado;
   logic error;
   logic ocupado;
   modport master (
      output start, dato_valid, dato_in,
      input dato_hora, dato_min, dato_seg, dato_dia, dato_mes, dato_year,
      input actualizado, error, ocupado
   );
   modport slave (
      input start, dato_valid, dato_in,
      output dato_hora, dato_min, dato_seg, dato_dia, dato_mes, dato_year,
      output actualizado, error, ocupado
   );
endinterface

// File: rtl/rtc_captura_datos.sv
// rtc_captura_datos: captures the six-byte RTC read burst into shadows, checks BCD and
// field ranges, and publishes a coherent snapshot only after a fully valid burst.
module rtc_captura_datos #(
   parameter int N = 8,
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic reset,
   rtc_captura_datos_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, CAPT = 2'd1, COMMIT = 2'd2;
   logic [1:0] state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic bad_q, bad_d;
   logic [15:0] cnt_q, cnt_d;
   logic act_d, act_q, err_d, err_q, acc;
   logic [N-1:0] sh_q [6];
   logic [N-1:0] out_q [6];
   // Valid BCD compares in the same order as the decimal value, so hex bounds suffice.
   function automatic logic byte_ok(input logic [2:0] i, input logic [7:0] d);
      logic [7:0] lo, hi;
      lo = (i == 3'd3 || i == 3'd4) ? 8'h01 : 8'h00;
      hi = i < 3'd2 ? 8'h59 : i == 3'd2 ? 8'h23 : i == 3'd3 ? 8'h31 : i == 3'd4 ? 8'h12 : 8'h99;
      return d[7:4] <= 4'd9 && d[3:0] <= 4'd9 && d >= lo && d <= hi;
   endfunction
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      bad_d = bad_q;
      cnt_d = cnt_q;
      acc = 1'b0;
      act_d = 1'b0;
      err_d = 1'b0;
      if (state_q == IDLE) begin
         if (bus.start) begin
            state_d = CAPT;
            idx_d = '0;
            bad_d = 1'b0;
            cnt_d = '0;
         end
      end else if (state_q == CAPT) begin
         if (bus.start) begin
            idx_d = '0;
            bad_d = 1'b0;
            cnt_d = '0;
         end else if (bus.dato_valid) begin
            acc = 1'b1;
            idx_d = idx_q + 3'd1;
            cnt_d = '0;
            bad_d = bad_q | ~byte_ok(idx_q, bus.dato_in[7:0]);
            state_d = idx_q == 3'd5 ? COMMIT : CAPT;
         end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            err_d = 1'b1;
            cnt_d = '0;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else begin
         state_d = IDLE;
         act_d = ~bad_q;
         err_d = bad_q;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q <= '0;
         bad_q <= 1'b0;
         cnt_q <= '0;
         act_q <= 1'b0;
         err_q <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            sh_q[i] <= '0;
            out_q[i] <= (i == 3 || i == 4) ? N'(1) : '0;
         end
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         bad_q <= bad_d;
         cnt_q <= cnt_d;
         act_q <= act_d;
         err_q <= err_d;
         if (acc) sh_q[idx_q] <= bus.dato_in;
         if (act_d) out_q <= sh_q;
      end
   end
   assign bus.dato_seg = out_q[0];
   assign bus.dato_min = out_q[1];
   assign bus.dato_hora = out_q[2];
   assign bus.dato_dia = out_q[3];
   assign bus.dato_mes = out_q[4];
   assign bus.dato_year = out_q[5];
   assign bus.actualizado = act_q;
   assign bus.error = err_q;
   assign bus.ocupado = state_q != IDLE;
endmodule

// File: tb/tb_rtc_captura_datos.sv
// tb_rtc_captura_datos: table vectors, directed corner sequences and random traffic
// checked against a burst-level model of the capture bank.
module tb_rtc_captura_datos;
   localparam int TO = 255;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   rtc_captura_datos_if #(.N(8)) bus ();
   rtc_captura_datos #(.N(8), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      logic s, v;
      logic [7:0] d;
      logic upd, err, busy;
   } vec_t;
   vec_t tbl[18];

   // Model: burst as a queue of bytes, validated as decimal fields once complete.
   logic [7:0] m_out[6];
   logic [7:0] m_q[$];
   bit m_busy, m_pend, m_upd, m_err;
   int m_idle;
   int f_lo[6] = '{0, 0, 0, 1, 1, 0};
   int f_hi[6] = '{59, 59, 23, 31, 12, 99};
   string f_nm[6] = '{"seg", "min", "hora", "dia", "mes", "year"};

   function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   function automatic bit burst_ok();
      for (int k = 0; k < 6; k++) begin
         int t = int'(m_q[k][7:4]);
         int u = int'(m_q[k][3:0]);
         if (t > 9 || u > 9 || t * 10 + u < f_lo[k] || t * 10 + u > f_hi[k]) return 0;
      end
      return 1;
   endfunction

   function automatic void model_reset();
      foreach (m_out[k]) m_out[k] = (k == 3 || k == 4) ? 8'h01 : 8'h00;
      m_q.delete();
      m_busy = 0; m_pend = 0; m_upd = 0; m_err = 0; m_idle = 0;
   endfunction

   function automatic void model_step(logic s, logic v, logic [7:0] d);
      m_upd = 0; m_err = 0;
      if (m_pend) begin
         m_pend = 0; m_busy = 0;
         if (burst_ok()) begin
            foreach (m_out[k]) m_out[k] = m_q[k];
            m_upd = 1;
         end else m_err = 1;
      end else if (m_busy) begin
         if (s) begin m_q.delete(); m_idle = 0; end
         else if (v) begin
            m_q.push_back(d); m_idle = 0;
            if (m_q.size() == 6) m_pend = 1;
         end else begin
            m_idle++;
            if (m_idle == TO) begin m_busy = 0; m_err = 1; end
         end
      end else if (s) begin
         m_busy = 1; m_q.delete(); m_idle = 0;
      end
   endfunction

   function automatic logic [7:0] dut_out(int k);
      case (k)
         0: return bus.dato_seg;
         1: return bus.dato_min;
         2: return bus.dato_hora;
         3: return bus.dato_dia;
         4: return bus.dato_mes;
         default: return bus.dato_year;
      endcase
   endfunction

   function automatic void compare_all();
      chk("actualizado", 8'(bus.actualizado), 8'(m_upd));
      chk("error", 8'(bus.error), 8'(m_err));
      chk("ocupado", 8'(bus.ocupado), 8'(m_busy));
      for (int k = 0; k < 6; k++) chk(f_nm[k], dut_out(k), m_out[k]);
   endfunction

   function automatic logic [7:0] gen_valid(int pos);
      int x = f_lo[pos] + int'($urandom_range(0, f_hi[pos] - f_lo[pos]));
      return {4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic cyc(input logic s, input logic v, input logic [7:0] d);
      bus.start = s; bus.dato_valid = v; bus.dato_in = d;
      @(posedge clk);
      #1;
      model_step(s, v, d);
      compare_all();
      bus.start = 1'b0; bus.dato_valid = 1'b0;
   endtask

   task automatic burst(input logic [7:0] b0, b1, b2, b3, b4, b5);
      cyc(1, 0, 0);
      cyc(0, 1, b0); cyc(0, 1, b1); cyc(0, 1, b2);
      cyc(0, 1, b3); cyc(0, 1, b4); cyc(0, 1, b5);
   endtask

   initial begin
      logic s, v;
      logic [7:0] d;
      int pos;
      tbl[0] = '{1, 0, 8'h00, 0, 0, 1};
      tbl[1] = '{0, 1, 8'h45, 0, 0, 1};
      tbl[2] = '{0, 1, 8'h30, 0, 0, 1};
      tbl[3] = '{0, 1, 8'h12, 0, 0, 1};
      tbl[4] = '{0, 1, 8'h15, 0, 0, 1};
      tbl[5] = '{0, 1, 8'h06, 0, 0, 1};
      tbl[6] = '{0, 1, 8'h16, 0, 0, 1};
      tbl[7] = '{0, 0, 8'h00, 1, 0, 0};
      tbl[8] = '{0, 0, 8'h00, 0, 0, 0};
      tbl[9] = '{1, 0, 8'h00, 0, 0, 1};
      tbl[10] = '{0, 1, 8'h45, 0, 0, 1};
      tbl[11] = '{0, 1, 8'h30, 0, 0, 1};
      tbl[12] = '{0, 1, 8'h24, 0, 0, 1};
      tbl[13] = '{0, 1, 8'h15, 0, 0, 1};
      tbl[14] = '{0, 1, 8'h06, 0, 0, 1};
      tbl[15] = '{0, 1, 8'h16, 0, 0, 1};
      tbl[16] = '{0, 0, 8'h00, 0, 1, 0};
      tbl[17] = '{0, 0, 8'h00, 0, 0, 0};
      bus.start = 1'b0; bus.dato_valid = 1'b0; bus.dato_in = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      compare_all();

      foreach (tbl[i]) begin
         cyc(tbl[i].s, tbl[i].v, tbl[i].d);
         chk("tbl_actualizado", 8'(bus.actualizado), 8'(tbl[i].upd));
         chk("tbl_error", 8'(bus.error), 8'(tbl[i].err));
         chk("tbl_ocupado", 8'(bus.ocupado), 8'(tbl[i].busy));
      end
      chk("held_seg", bus.dato_seg, 8'h45);
      chk("held_min", bus.dato_min, 8'h30);
      chk("held_hora", bus.dato_hora, 8'h12);
      chk("held_dia", bus.dato_dia, 8'h15);
      chk("held_mes", bus.dato_mes, 8'h06);
      chk("held_year", bus.dato_year, 8'h16);

      burst(8'h10, 8'h5A, 8'h10, 8'h00, 8'h01, 8'h20);
      cyc(0, 0, 0);
      chk("badnib_error", 8'(bus.error), 8'd1);
      chk("badnib_hora", bus.dato_hora, 8'h12);

      cyc(1, 0, 0);
      cyc(0, 1, 8'h01); cyc(0, 1, 8'h02); cyc(0, 1, 8'h03);
      repeat (TO - 1) cyc(0, 0, 0);
      chk("timeout_early", 8'(bus.error), 8'd0);
      cyc(0, 0, 0);
      chk("timeout_error", 8'(bus.error), 8'd1);
      chk("timeout_ocupado", 8'(bus.ocupado), 8'd0);
      repeat (3) cyc(0, 1, 8'h11);

      cyc(1, 0, 0);
      cyc(0, 1, 8'h11); cyc(0, 1, 8'h22); cyc(0, 1, 8'h13); cyc(0, 1, 8'h14);
      burst(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
      cyc(0, 0, 0);
      chk("restart_upd", 8'(bus.actualizado), 8'd1);
      chk("restart_dia", bus.dato_dia, 8'h01);
      cyc(1, 1, 8'h33);
      cyc(0, 0, 0);

      cyc(0, 1, 8'h10); cyc(0, 1, 8'h20);
      bus.dato_valid = 1'b1; bus.dato_in = 8'h05;
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      bus.dato_valid = 1'b0;
      reset = 1'b0;
      compare_all();
      repeat (7) cyc(0, 1, 8'h02);
      chk("postrst_year", bus.dato_year, 8'h00);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) repeat (TO) cyc(0, 0, 0);
         s = $urandom_range(0, 39) == 0;
         v = $urandom_range(0, 9) < 7;
         pos = m_q.size() < 6 ? m_q.size() : 0;
         d = $urandom_range(0, 4) == 0 ? 8'($urandom) : gen_valid(pos);
         cyc(s, v, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
